// File: rtl/gen_crd_mng_pkg.sv
// Shared helpers for the multi-channel credit manager.
// crd_sat_next applies one cycle of grant/use to a count and saturates it at 0 and init.
package gen_crd_mng_pkg;

  // Returns {next_cnt[31:0], ovf, udf}. The sum is signed so underflow shows up as a negative value.
  function automatic logic [33:0] crd_sat_next(input logic signed [31:0] cnt,
                                               input logic signed [31:0] g,
                                               input logic signed [31:0] u,
                                               input logic signed [31:0] init);
    logic signed [31:0] n;
    logic ovf;
    logic udf;
    n   = cnt + g - u;
    ovf = 1'b0;
    udf = 1'b0;
    if (n < 0) begin
      n   = 32'sd0;
      udf = 1'b1;
    end else if (n > init) begin
      n   = init;
      ovf = 1'b1;
    end
    return {n, ovf, udf};
  endfunction

endpackage

// File: rtl/gen_crd_mng_ch.sv
// One credit channel: saturating counter, sticky overflow/underflow flags, status decode.
// Status outputs are decoded combinationally from the registered count.
module gen_crd_mng_ch
  import gen_crd_mng_pkg::*;
#(
  parameter int CRD_INIT_AMOUNT  = 8,
  parameter int MAX_CRD_USED_VAL = 1,
  parameter int LOW_WM           = 1,
  parameter int CNT_W            = 4,
  parameter int GRNT_W           = 1,
  parameter int USED_W           = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grnt_en,
  input  logic [GRNT_W-1:0] grnt_val,
  input  logic              used_en,
  input  logic [USED_W-1:0] used_val,
  input  logic              reinit,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  cnt,
  output logic              exist,
  output logic              low,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  logic signed [31:0] g;
  logic signed [31:0] u;
  logic [33:0]        sat;
  logic [CNT_W-1:0]   cnt_p0;
  logic               ovf_p0;
  logic               udf_p0;
  logic               unused_sat_hi;

  always_comb begin
    g   = grnt_en ? $signed({{(32-GRNT_W){1'b0}}, grnt_val}) : 32'sd0;
    u   = used_en ? $signed({{(32-USED_W){1'b0}}, used_val}) : 32'sd0;
    sat = crd_sat_next($signed({{(32-CNT_W){1'b0}}, cnt_p0}), g, u, CRD_INIT_AMOUNT);
  end

  assign unused_sat_hi = ^sat[33:CNT_W+2];

  // Stage p0: count and sticky flags; reinit discards this cycle's traffic, a new error beats err_clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0 <= CNT_W'(CRD_INIT_AMOUNT);
      ovf_p0 <= 1'b0;
      udf_p0 <= 1'b0;
    end else begin
      cnt_p0 <= reinit ? CNT_W'(CRD_INIT_AMOUNT) : sat[CNT_W+1:2];
      ovf_p0 <= (ovf_p0 & ~err_clr) | (sat[1] & ~reinit);
      udf_p0 <= (udf_p0 & ~err_clr) | (sat[0] & ~reinit);
    end
  end

  assign cnt   = cnt_p0;
  assign ovf   = ovf_p0;
  assign udf   = udf_p0;
  assign exist = (cnt_p0 >= CNT_W'(MAX_CRD_USED_VAL));
  assign low   = (cnt_p0 <= CNT_W'(LOW_WM));
  assign full  = (cnt_p0 == CNT_W'(CRD_INIT_AMOUNT));

endmodule

// File: rtl/gen_crd_mng_mc.sv
// Multi-channel credit manager: NUM_CH independent credit pools on the sender side of a link.
// Each channel is a gen_crd_mng_ch; err_any is a registered summary of all sticky flags.
module gen_crd_mng_mc #(
  parameter int NUM_CH           = 4,
  parameter int CRD_INIT_AMOUNT  = 8,
  parameter int MAX_CRD_GRNT_VAL = 1,
  parameter int MAX_CRD_USED_VAL = 1,
  parameter int LOW_WM           = 1,
  localparam int CRD_CNT_W       = $clog2(CRD_INIT_AMOUNT + 1),
  localparam int CRD_GRNT_W      = $clog2(MAX_CRD_GRNT_VAL + 1),
  localparam int CRD_USED_W      = $clog2(MAX_CRD_USED_VAL + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            crd_grnt_en,
  input  logic [NUM_CH*CRD_GRNT_W-1:0] crd_grnt_val,
  input  logic [NUM_CH-1:0]            crd_used_en,
  input  logic [NUM_CH*CRD_USED_W-1:0] crd_used_val,
  input  logic [NUM_CH-1:0]            crd_reinit,
  input  logic [NUM_CH-1:0]            err_clr,
  output logic [NUM_CH*CRD_CNT_W-1:0]  crd_cnt,
  output logic [NUM_CH-1:0]            crd_exist,
  output logic [NUM_CH-1:0]            crd_low,
  output logic [NUM_CH-1:0]            crd_full,
  output logic [NUM_CH-1:0]            err_ovf,
  output logic [NUM_CH-1:0]            err_udf,
  output logic                         err_any
);

  logic err_any_p0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gen_crd_mng_ch #(
      .CRD_INIT_AMOUNT  (CRD_INIT_AMOUNT),
      .MAX_CRD_USED_VAL (MAX_CRD_USED_VAL),
      .LOW_WM           (LOW_WM),
      .CNT_W            (CRD_CNT_W),
      .GRNT_W           (CRD_GRNT_W),
      .USED_W           (CRD_USED_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .grnt_en  (crd_grnt_en[i]),
      .grnt_val (crd_grnt_val[i*CRD_GRNT_W +: CRD_GRNT_W]),
      .used_en  (crd_used_en[i]),
      .used_val (crd_used_val[i*CRD_USED_W +: CRD_USED_W]),
      .reinit   (crd_reinit[i]),
      .err_clr  (err_clr[i]),
      .cnt      (crd_cnt[i*CRD_CNT_W +: CRD_CNT_W]),
      .exist    (crd_exist[i]),
      .low      (crd_low[i]),
      .full     (crd_full[i]),
      .ovf      (err_ovf[i]),
      .udf      (err_udf[i])
    );
  end

  // Stage p1: summary flag lags the per-channel flags by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) err_any_p0 <= 1'b0;
    else        err_any_p0 <= |(err_ovf | err_udf);
  end

  assign err_any = err_any_p0;

endmodule
